writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage of the RISC-V core: holds one retiring instruction from the memory stage, waits for load data when needed, aligns and extends load bytes/halfwords, selects the writeback source and drives the register file write port (reg_write, write_reg, write_data). The outputs are driven from stage flops only, so the register file's same-cycle write-to-read bypass never sees a combinational path from memory-stage inputs. A retired-instruction counter is provided for SQED consistency checks.

## Interface
- CNT_WIDTH, 64, width of retire_count
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  memory stage presents an instruction
- in_ready  output  1  stage accepts an instruction this cycle
- flush  input  1  kill incoming and waiting-load instruction
- in_reg_write  input  1  instruction writes rd
- in_rd  input  5  destination register
- in_wb_sel  input  2  00 ALU result, 01 load data, 10 PC+4, 11 treated as 00
- in_alu_result  input  32  ALU result
- in_pc4  input  32  PC+4 (link value)
- in_funct3  input  3  load width/sign
- in_addr_lo  input  2  load address bits [1:0]
- dmem_rvalid  input  1  load response valid
- dmem_rdata  input  32  load response word
- reg_write  output  1  register file write enable
- write_reg  output  5  register file write index
- write_data  output  32  register file write data
- busy  output  1  waiting for load response
- retire_count  output  CNT_WIDTH  instructions committed since reset

## Operation
- States: IDLE (empty), WAIT_LD (load accepted, data pending), COMMIT (entry final, outputs active).
- in_ready = 1 in IDLE and COMMIT, 0 in WAIT_LD. busy = (state == WAIT_LD).
- Accept = in_valid & in_ready & ~flush. On accept: wb_sel 01 -> WAIT_LD; otherwise -> COMMIT with write_data = in_pc4 (sel 10) or in_alu_result (sel 00/11).
- IDLE/COMMIT with no accept -> IDLE. COMMIT and accept in the same cycle is legal (back-to-back).
- WAIT_LD: on dmem_rvalid capture aligned data -> COMMIT; else hold. dmem_rvalid ignored in IDLE and COMMIT.
- Load alignment: byte = dmem_rdata >> (8*addr_lo); half = dmem_rdata >> (16*addr_lo[1]) (addr_lo[0] ignored); funct3 000 LB sign-extend byte, 001 LH sign-extend half, 100 LBU zero-extend byte, 101 LHU zero-extend half, 010 and all other codes full word.
- reg_write = (state == COMMIT) & entry reg_write & (entry rd != 0). write_reg/write_data show entry values in COMMIT; 0 in all other states.
- retire_count += 1 on every COMMIT cycle regardless of reg_write; wraps modulo 2^CNT_WIDTH.
- flush: blocks accept that cycle; WAIT_LD -> IDLE with entry dropped (a coinciding dmem_rvalid is discarded, entry not committed). An entry already in COMMIT still commits that cycle.
- reset: state IDLE, reg_write/write_reg/write_data/busy 0, retire_count 0, in_ready 1 the cycle after. Reset overrides flush, accept and rvalid.

## Timing
- Non-load: accepted at edge N, committed (outputs asserted) in cycle N+1 for exactly one cycle. Throughput one per cycle.
- Load: accepted at edge N, earliest rvalid in cycle N+1; rvalid sampled at edge M -> commit in cycle M+1. Minimum load latency accept-to-commit 2 cycles.
- in_ready depends only on state (no combinational path from in_valid or dmem_rvalid).
- retire_count reflects a commit at the edge ending the COMMIT cycle.

## Test plan
- Reset then ALU op in_rd=5, alu_result=0x1234, reg_write=1 -> next cycle reg_write=1, write_reg=5, write_data=0x1234; retire_count=1 afterwards.
- JAL-style sel=10, in_pc4=0x104, rd=1, followed back-to-back by ALU rd=0 -> cycle 1 writes x1=0x104; cycle 2 reg_write=0, retire_count=2.
- LB addr_lo=3, rdata=0x80FF_0011, rvalid 3 cycles after accept -> in_ready=0, busy=1 for 3 cycles, then write_data=0xFFFF_FF80; LHU addr_lo=2 same data -> 0x0000_80FF; LH addr_lo=1 -> 0x0000_0011.
- Load in WAIT_LD, flush asserted with dmem_rvalid same cycle -> no commit, state IDLE, retire_count unchanged, in_ready=1 next cycle.
- Reset asserted while in COMMIT with pending in_valid -> next cycle all outputs 0, retire_count=0, no write.
- Preload retire_count near wrap (CNT_WIDTH=4, 16 commits) -> count returns to 0.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Holds one retiring instruction,
// waits for load data when needed, aligns/extends loads and drives the
// register file write port from stage flops only.
module writeback_stage #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    input  logic                 in_reg_write,
    input  logic [4:0]           in_rd,
    input  logic [1:0]           in_wb_sel,
    input  logic [31:0]          in_alu_result,
    input  logic [31:0]          in_pc4,
    input  logic [2:0]           in_funct3,
    input  logic [1:0]           in_addr_lo,
    input  logic                 dmem_rvalid,
    input  logic [31:0]          dmem_rdata,
    output logic                 reg_write,
    output logic [4:0]           write_reg,
    output logic [31:0]          write_data,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] retire_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LD = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                r_state;
    logic                  r_ld_we;
    logic [4:0]            r_ld_rd;
    logic [2:0]            r_ld_funct3;
    logic [1:0]            r_ld_addr_lo;
    logic                  r_reg_write;
    logic [4:0]            r_write_reg;
    logic [31:0]           r_write_data;
    logic [CNT_WIDTH-1:0]  r_count;

    logic                  w_accept;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_ld_data;

    // Ready/busy decode from state only: no path from in_valid or rvalid.
    assign in_ready = (r_state != WAIT_LD);
    assign busy     = (r_state == WAIT_LD);
    assign w_accept = in_valid & in_ready & ~flush;

    assign reg_write    = r_reg_write;
    assign write_reg    = r_write_reg;
    assign write_data   = r_write_data;
    assign retire_count = r_count;

    // Pick the addressed byte/halfword of the load response word.
    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (r_ld_addr_lo)
            2'd0: w_byte = dmem_rdata[7:0];
            2'd1: w_byte = dmem_rdata[15:8];
            2'd2: w_byte = dmem_rdata[23:16];
            2'd3: w_byte = dmem_rdata[31:24];
            default: w_byte = dmem_rdata[7:0];
        endcase
        w_half = r_ld_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    end

    // Sign/zero extension by load width; unknown widths load the full word.
    always_comb begin
        w_ld_data = dmem_rdata;
        case (r_ld_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'd0, w_byte};
            3'b101:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = dmem_rdata;
        endcase
    end

    // Stage FSM; write-port outputs are registered so they are only
    // nonzero during the COMMIT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ld_we      <= 1'b0;
            r_ld_rd      <= 5'd0;
            r_ld_funct3  <= 3'd0;
            r_ld_addr_lo <= 2'd0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= 5'd0;
            r_write_data <= 32'd0;
            r_count      <= '0;
        end else begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= 5'd0;
            r_write_data <= 32'd0;
            if (r_state == COMMIT)
                r_count <= r_count + CNT_ONE;
            case (r_state)
                IDLE, COMMIT: begin
                    if (w_accept) begin
                        if (in_wb_sel == 2'b01) begin
                            r_state      <= WAIT_LD;
                            r_ld_we      <= in_reg_write;
                            r_ld_rd      <= in_rd;
                            r_ld_funct3  <= in_funct3;
                            r_ld_addr_lo <= in_addr_lo;
                        end else begin
                            r_state      <= COMMIT;
                            r_reg_write  <= in_reg_write & (in_rd != 5'd0);
                            r_write_reg  <= in_rd;
                            r_write_data <= (in_wb_sel == 2'b10) ? in_pc4 : in_alu_result;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT_LD: begin
                    // Flush drops the pending load even if data arrives now.
                    if (flush) begin
                        r_state <= IDLE;
                    end else if (dmem_rvalid) begin
                        r_state      <= COMMIT;
                        r_reg_write  <= r_ld_we & (r_ld_rd != 5'd0);
                        r_write_reg  <= r_ld_rd;
                        r_write_data <= w_ld_data;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with an expected-commit queue.
module tb_writeback_stage;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc4;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        busy;
    logic [3:0]  retire_count;

    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;
    exp_t q[$];

    writeback_stage #(.CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .in_reg_write(in_reg_write), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result), .in_pc4(in_pc4),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .busy(busy), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic we, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4);
        in_valid = 1'b1; in_wb_sel = sel; in_reg_write = we; in_rd = rd;
        in_alu_result = alu; in_pc4 = pc4;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_wb_sel = 2'b00; in_reg_write = 1'b0; in_rd = 5'd0;
        in_alu_result = $urandom; in_pc4 = $urandom;
    endtask

    // Pop the oldest expected commit and compare the write port against it.
    task automatic check_commit(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = q.pop_front();
            chk({tag, "_reg_write"}, 64'(reg_write), 64'(e.we && e.rd != 5'd0));
            chk({tag, "_write_reg"}, 64'(write_reg), 64'(e.rd));
            chk({tag, "_write_data"}, 64'(write_data), 64'(e.data));
            chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
            chk({tag, "_cnt"}, 64'(retire_count), 64'(exp_cnt));
            exp_cnt = (exp_cnt + 1) % 16;
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_reg_write"}, 64'(reg_write), 64'd0);
        chk({tag, "_write_reg"}, 64'(write_reg), 64'd0);
        chk({tag, "_write_data"}, 64'(write_data), 64'd0);
        chk({tag, "_cnt"}, 64'(retire_count), 64'(exp_cnt));
    endtask

    // Load with rvalid in the dly-th cycle after accept.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] a,
                           input logic [31:0] rdata, input int dly,
                           input logic [4:0] rd, input logic [31:0] expd);
        drive(2'b01, 1'b1, rd, $urandom, $urandom);
        in_funct3 = f3; in_addr_lo = a;
        step();
        idle_in();
        in_funct3 = $urandom; in_addr_lo = $urandom;
        dmem_rdata = rdata;
        for (int i = 0; i < dly; i++) begin
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            chk({tag, "_ready"}, 64'(in_ready), 64'd0);
            chk({tag, "_wr_hold"}, 64'(reg_write), 64'd0);
            dmem_rvalid = (i == dly - 1);
            step();
        end
        dmem_rvalid = 1'b0;
        dmem_rdata = $urandom;
        q.push_back('{we: 1'b1, rd: rd, data: expd});
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        check_commit(tag);
        step();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        in_funct3 = 3'd0; in_addr_lo = 2'd0;
        idle_in();
        step(); step();
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        check_quiet("rst");

        // Single ALU op
        drive(2'b00, 1'b1, 5'd5, 32'h1234, 32'h8);
        q.push_back('{we: 1'b1, rd: 5'd5, data: 32'h1234});
        step();
        idle_in();
        check_commit("alu");
        step();
        check_quiet("alu_after");

        // JAL link then back-to-back ALU to x0; sel 11 treated as ALU
        drive(2'b10, 1'b1, 5'd1, 32'hDEAD, 32'h104);
        q.push_back('{we: 1'b1, rd: 5'd1, data: 32'h104});
        step();
        drive(2'b00, 1'b1, 5'd0, 32'h55, 32'h200);
        check_commit("jal");
        q.push_back('{we: 1'b1, rd: 5'd0, data: 32'h55});
        step();
        drive(2'b11, 1'b0, 5'd9, 32'hCAFE, 32'h300);
        check_commit("x0");
        q.push_back('{we: 1'b0, rd: 5'd9, data: 32'hCAFE});
        step();
        idle_in();
        check_commit("sel11");
        step();
        check_quiet("b2b_after");

        // rvalid while idle is ignored
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        step();
        dmem_rvalid = 1'b0;
        chk("idle_rvalid_busy", 64'(busy), 64'd0);
        check_quiet("idle_rvalid");

        // Load alignment / extension
        do_load("lb3",  3'b000, 2'd3, 32'h80FF_0011, 3, 5'd7,  32'hFFFF_FF80);
        do_load("lhu2", 3'b101, 2'd2, 32'h80FF_0011, 1, 5'd8,  32'h0000_80FF);
        do_load("lh1",  3'b001, 2'd1, 32'h80FF_0011, 2, 5'd9,  32'h0000_0011);
        do_load("lw",   3'b010, 2'd1, 32'h80FF_0011, 1, 5'd10, 32'h80FF_0011);
        do_load("lbu0", 3'b100, 2'd0, 32'h1234_56F8, 1, 5'd11, 32'h0000_00F8);
        do_load("lb2",  3'b000, 2'd2, 32'h12FF_5678, 1, 5'd12, 32'hFFFF_FFFF);
        do_load("lh3",  3'b001, 2'd3, 32'h80FF_0011, 1, 5'd13, 32'hFFFF_80FF);
        do_load("f111", 3'b111, 2'd2, 32'hA5A5_5A5A, 1, 5'd14, 32'hA5A5_5A5A);

        // Flush in WAIT_LD with coinciding rvalid drops the load
        drive(2'b01, 1'b1, 5'd15, 32'd0, 32'd0);
        in_funct3 = 3'b010;
        step();
        idle_in();
        chk("fl_busy", 64'(busy), 64'd1);
        flush = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
        step();
        flush = 1'b0; dmem_rvalid = 1'b0;
        chk("fl_busy_clr", 64'(busy), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        check_quiet("fl_ld");
        step();
        check_quiet("fl_ld2");

        // Flush blocks accept in IDLE
        drive(2'b00, 1'b1, 5'd3, 32'h99, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_in();
        check_quiet("fl_block");

        // Entry in COMMIT still commits under flush; new input blocked
        drive(2'b00, 1'b1, 5'd4, 32'h4444, 32'd0);
        q.push_back('{we: 1'b1, rd: 5'd4, data: 32'h4444});
        step();
        drive(2'b00, 1'b1, 5'd6, 32'h6666, 32'd0);
        flush = 1'b1;
        check_commit("fl_commit");
        step();
        flush = 1'b0;
        idle_in();
        check_quiet("fl_commit_after");

        // Reset while in COMMIT with pending in_valid
        drive(2'b00, 1'b1, 5'd3, 32'h3333, 32'd0);
        q.push_back('{we: 1'b1, rd: 5'd3, data: 32'h3333});
        step();
        drive(2'b00, 1'b1, 5'd2, 32'h2222, 32'd0);
        reset = 1'b1;
        check_commit("pre_rst");
        step();
        reset = 1'b0;
        idle_in();
        exp_cnt = 0;
        chk("rst2_ready", 64'(in_ready), 64'd1);
        check_quiet("rst2");
        step();
        check_quiet("rst2_after");

        // 16 back-to-back commits wrap the 4-bit counter
        drive(2'b00, 1'b1, 5'd1, 32'h1000, 32'd0);
        q.push_back('{we: 1'b1, rd: 5'd1, data: 32'h1000});
        step();
        for (int i = 1; i < 16; i++) begin
            drive(2'b00, 1'b1, 5'(i + 1), 32'h1000 + 32'(i), 32'd0);
            check_commit("wrap");
            q.push_back('{we: 1'b1, rd: 5'(i + 1), data: 32'h1000 + 32'(i)});
            step();
        end
        idle_in();
        check_commit("wrap_last");
        step();
        chk("wrap_zero", 64'(retire_count), 64'd0);
        check_quiet("wrap_after");

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
